// File: rtl/uarch_trace_pkg.sv
// Shared types and helpers for the pipeline-trace encoder: event codes,
// record kinds and the record-width calculation.
package uarch_trace_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_SINGLE = 2'b01,
    EV_START  = 2'b10,
    EV_END    = 2'b11
  } ev_code_e;

  localparam logic KIND_EVENT = 1'b0;
  localparam logic KIND_OVF   = 1'b1;

  function automatic int rec_width(input int num_stages, input int pc_w, input int ts_w);
    return 1 + ts_w + 2 * num_stages + pc_w * num_stages;
  endfunction

  // mc marks an instruction that was already in the stage last cycle and
  // has not completed yet, so a completion now ends a multicycle run.
  function automatic ev_code_e ev_classify(input logic busy, input logic done, input logic mc);
    ev_code_e code;
    code = EV_NONE;
    if (busy && done) begin
      code = mc ? EV_END : EV_SINGLE;
    end else if (busy && !mc) begin
      code = EV_START;
    end
    return code;
  endfunction

endpackage

// File: rtl/uarch_trace_fifo.sv
// DEPTH x WIDTH synchronous FIFO with a registered head-of-queue output.
// A write into an empty FIFO is visible on rdata one cycle later.
module uarch_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              push_ok, pop_ok;

  always_comb begin
    push_ok = push && (fill_q != FILL_W'(DEPTH));
    pop_ok  = pop && (fill_q != '0);
    rd_nxt  = rd_q + 1'b1;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_nxt : rd_q;

    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    // The head register tracks whatever entry will sit at rd_d after this
    // edge; with a single entry left, that successor is the incoming word.
    rdata_d = rdata_q;
    if (pop_ok) begin
      rdata_d = (fill_q == FILL_W'(1)) ? wdata : mem[rd_nxt];
    end else if (push_ok && (fill_q == '0)) begin
      rdata_d = wdata;
    end
  end

  // NOTE: storage array has no reset; validity is tracked by fill/pointers,
  // which keeps the array free to map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_q] <= wdata;
    end
  end

  // NOTE: all state uses non-blocking assignment so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

endmodule

// File: rtl/uarch_trace_encoder.sv
// Pipeline-trace encoder: classifies per-stage activity into events, packs
// timestamped records, and queues them with in-band overflow markers.
module uarch_trace_encoder
  import uarch_trace_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int PC_W       = 32,
  parameter int TS_W       = 16,
  parameter int DEPTH      = 8,
  parameter int DROP_W     = 16,
  localparam int REC_W     = rec_width(NUM_STAGES, PC_W, TS_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trace_en,
  input  logic [NUM_STAGES-1:0]        stage_busy,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [PC_W*NUM_STAGES-1:0]   stage_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [REC_W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]       fill
);

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int EV_W   = 2 * NUM_STAGES;
  localparam int PCS_W  = PC_W * NUM_STAGES;

  logic [NUM_STAGES-1:0] busy_q, busy_d, done_q, done_d, mc;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic [EV_W-1:0]       ev;
  logic                  ev_any, space, push, pop, empty;
  logic [PCS_W-1:0]      pc_ovf;
  logic [REC_W-1:0]      wdata;
  logic [FILL_W-1:0]     fill_w;

  assign mc = busy_q & ~done_q;

  always_comb begin
    ev = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ev[2*i +: 2] = ev_classify(stage_busy[i], stage_done[i], mc[i]);
    end
    ev_any = trace_en && (ev != '0);
  end

  always_comb begin
    busy_d = trace_en ? stage_busy : '0;
    done_d = trace_en ? stage_done : '0;
    ts_d   = ts_q + 1'b1;
  end

  // Space is judged on the start-of-cycle fill; a same-cycle pop never
  // makes room, so a full FIFO always refuses the write.
  assign space = (fill_w < FILL_W'(DEPTH));

  always_comb begin
    pc_ovf                = '0;
    pc_ovf[DROP_W-1:0]    = drop_q;
    push                  = 1'b0;
    wdata                 = {KIND_EVENT, ts_q, ev, stage_pc};
    drop_d                = drop_q;
    if ((drop_q != '0) && space) begin
      push   = 1'b1;
      wdata  = {KIND_OVF, ts_q, {EV_W{1'b0}}, pc_ovf};
      drop_d = ev_any ? DROP_W'(1) : '0;
    end else if (ev_any && space) begin
      push = 1'b1;
    end else if (ev_any && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      done_q <= '0;
      ts_q   <= '0;
      drop_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      ts_q   <= ts_d;
      drop_q <= drop_d;
    end
  end

  assign pop       = ~empty & out_ready;
  assign out_valid = ~empty;
  assign fill      = fill_w;

  uarch_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (out_data),
    .empty (empty),
    .fill  (fill_w)
  );

endmodule

// File: tb/tb_uarch_trace_encoder.sv
// Randomized and directed bench for uarch_trace_encoder against a queue-based
// behavioural model of the record stream.
module tb_uarch_trace_encoder;

  localparam int NS  = 3;
  localparam int PW  = 32;
  localparam int TW  = 4;
  localparam int D   = 8;
  localparam int DW  = 16;
  localparam int RW  = 1 + TW + 2 * NS + PW * NS;
  localparam int PCS = PW * NS;
  localparam int EV_LO = PCS;
  localparam int TS_LO = PCS + 2 * NS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           trace_en = 1'b0;
  logic [NS-1:0]  stage_busy = '0;
  logic [NS-1:0]  stage_done = '0;
  logic [PCS-1:0] stage_pc = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [RW-1:0]  out_data;
  logic [$clog2(D):0] fill;

  uarch_trace_encoder #(
    .NUM_STAGES (NS),
    .PC_W       (PW),
    .TS_W       (TW),
    .DEPTH      (D),
    .DROP_W     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .stage_busy (stage_busy),
    .stage_done (stage_done),
    .stage_pc   (stage_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: records in flight, last-cycle stage activity,
  // timestamp and number of lost records.
  logic [RW-1:0] mq[$];
  bit            was_busy[NS];
  bit            was_done[NS];
  int            m_ts;
  int            m_lost;
  logic [RW-1:0] popped[$];

  task automatic model_clock();
    logic [2*NS-1:0] ev;
    logic [PCS-1:0]  pcf;
    bit              has_ev, room, continuing;
    if (rst) begin
      mq.delete();
      foreach (was_busy[i]) begin
        was_busy[i] = 0;
        was_done[i] = 0;
      end
      m_ts   = 0;
      m_lost = 0;
      return;
    end
    ev = '0;
    for (int i = 0; i < NS; i++) begin
      continuing = was_busy[i] && !was_done[i];
      if (stage_busy[i] && stage_done[i])
        ev[2*i +: 2] = continuing ? 2'b11 : 2'b01;
      else if (stage_busy[i] && !continuing)
        ev[2*i +: 2] = 2'b10;
    end
    has_ev = trace_en && (ev != '0);
    room   = mq.size() < D;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (m_lost > 0 && room) begin
      pcf = '0;
      pcf[DW-1:0] = DW'(m_lost);
      mq.push_back({1'b1, TW'(m_ts), {(2*NS){1'b0}}, pcf});
      m_lost = has_ev ? 1 : 0;
    end else if (has_ev && room) begin
      mq.push_back({1'b0, TW'(m_ts), ev, stage_pc});
    end else if (has_ev && m_lost < (1 << DW) - 1) begin
      m_lost++;
    end
    for (int i = 0; i < NS; i++) begin
      was_busy[i] = trace_en && stage_busy[i];
      was_done[i] = trace_en && stage_done[i];
    end
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic cycle(input bit r, input bit en, input logic [NS-1:0] b,
                       input logic [NS-1:0] d, input logic [PCS-1:0] pc, input bit rdy);
    @(negedge clk);
    rst = r; trace_en = en; stage_busy = b; stage_done = d; stage_pc = pc; out_ready = rdy;
    #1;
    if (!r && out_valid && out_ready) popped.push_back(out_data);
    model_clock();
    @(posedge clk);
    #1;
    check("out_valid", RW'(out_valid), RW'(mq.size() > 0));
    check("fill", RW'(fill), RW'(mq.size()));
    if (mq.size() > 0) check("out_data", out_data, mq[0]);
    if (r) check("rst_out_data", out_data, '0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(0, 1, '0, '0, '0, rdy);
  endtask

  initial begin
    // Single-cycle event at ts 5.
    cycle(1, 0, '0, '0, '0, 0);
    idle(5, 0);
    cycle(0, 1, 3'b001, 3'b001, PCS'(32'h100), 0);
    check("t1_valid", RW'(out_valid), RW'(1));
    check("t1_kind", RW'(out_data[RW-1]), RW'(0));
    check("t1_ts", RW'(out_data[TS_LO +: TW]), RW'(5));
    check("t1_ev", RW'(out_data[EV_LO +: 2*NS]), RW'(6'b000001));
    check("t1_pc0", RW'(out_data[0 +: PW]), RW'(32'h100));

    // Multicycle on stage1: START, nothing, END.
    cycle(1, 0, '0, '0, '0, 1);
    cycle(0, 1, 3'b010, 3'b000, {32'h0, 32'h200, 32'h0}, 1);
    check("t2_start", RW'(out_data[EV_LO +: 2*NS]), RW'(6'b001000));
    cycle(0, 1, 3'b010, 3'b000, {32'h0, 32'h200, 32'h0}, 1);
    check("t2_quiet", RW'(out_valid), RW'(0));
    cycle(0, 1, 3'b010, 3'b010, {32'h0, 32'h200, 32'h0}, 1);
    check("t2_end", RW'(out_data[EV_LO +: 2*NS]), RW'(6'b001100));
    check("t2_pc1", RW'(out_data[PW +: PW]), RW'(32'h200));

    // All three stages SINGLE together.
    idle(2, 1);
    cycle(0, 1, 3'b111, 3'b111, {32'hC0C0, 32'hB0B0, 32'hA0A0}, 1);
    check("t3_ev", RW'(out_data[EV_LO +: 2*NS]), RW'(6'b010101));
    check("t3_pcs", RW'(out_data[0 +: PCS]), RW'({32'hC0C0, 32'hB0B0, 32'hA0A0}));
    cycle(0, 1, '0, '0, '0, 1);
    check("t3_one_rec", RW'(out_valid), RW'(0));

    // Overflow: 10 events into an 8-deep FIFO with no sink, then drain.
    cycle(1, 0, '0, '0, '0, 0);
    for (int k = 0; k < 10; k++) cycle(0, 1, 3'b001, 3'b001, PCS'(k), 0);
    check("t4_fill_full", RW'(fill), RW'(8));
    popped.delete();
    for (int k = 0; k < 20 && (k < 2 || out_valid); k++) idle(1, 1);
    check("t4_delivered", RW'(popped.size()), RW'(9));
    if (popped.size() >= 9) begin
      check("t4_marker_kind", RW'(popped[8][RW-1]), RW'(1));
      check("t4_marker_cnt", RW'(popped[8][0 +: PCS]), RW'(2));
    end

    // Timestamp wrap at TS_W=4.
    cycle(1, 0, '0, '0, '0, 1);
    idle(15, 1);
    cycle(0, 1, 3'b001, 3'b001, PCS'(32'h15), 1);
    check("t5_ts15", RW'(out_data[TS_LO +: TW]), RW'(15));
    cycle(0, 1, 3'b001, 3'b001, PCS'(32'h16), 1);
    check("t5_ts0", RW'(out_data[TS_LO +: TW]), RW'(0));

    // Reset with a full FIFO and pending drops.
    cycle(1, 0, '0, '0, '0, 0);
    for (int k = 0; k < 11; k++) cycle(0, 1, 3'b001, 3'b001, PCS'(k), 0);
    cycle(1, 1, '0, '0, '0, 0);
    check("t6_fill", RW'(fill), RW'(0));
    check("t6_valid", RW'(out_valid), RW'(0));
    cycle(0, 1, 3'b001, 3'b001, PCS'(32'h77), 0);
    check("t6_kind", RW'(out_data[RW-1]), RW'(0));
    check("t6_ts", RW'(out_data[TS_LO +: TW]), RW'(0));
    check("t6_fill1", RW'(fill), RW'(1));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 250) == 0, ($urandom % 8) != 0, NS'($urandom), NS'($urandom),
            {$urandom, $urandom, $urandom}, (k / 64) % 3 == 1 ? ($urandom % 6 == 0) : ($urandom % 3 != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
